ahb_slave_mem: RTL
==================

# ahb_slave_mem

Synthesizable AHB slave memory placed directly downstream of the WISHBONE-to-AHB bridge. It consumes the bridge's AHB master signals (haddr, hwrite, htrans, hsize, hburst, hwdata) and returns hready, hresp and hrdata. It supports programmable wait states, byte/halfword/word writes and a two-cycle ERROR response, so the bridge's pipelining, stall and error paths can be exercised in both simulation and FPGA builds.

## Interface
- AWIDTH, from package global: address width.
- DWIDTH, from package global: data width, fixed at 32.
- DEPTH, 1024: number of 32-bit words; valid byte addresses are 0 .. DEPTH*4-1.
- WAIT_STATES, 0: hready-low cycles inserted in every OKAY data phase, range 0..15.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- haddr  in  AWIDTH  byte address, address phase.
- hwrite  in  1  1 = write, 0 = read, address phase.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hsize  in  3  000 byte, 001 halfword, 010 word; any other value is an error.
- hburst  in  3  accepted but ignored; every beat is decoded independently.
- hwdata  in  DWIDTH  write data, data phase.
- hready  out  1  transfer-complete / slave ready.
- hresp  out  2  00 OKAY, 01 ERROR; 10 and 11 are never driven.
- hrdata  out  DWIDTH  read data, data phase.

## Operation
- The slave is always selected; it has no hsel input.
- An address phase is accepted on any rising edge where hready=1 and htrans[1]=1 (NONSEQ or SEQ). It registers addr_q, write_q and size_q.
- IDLE and BUSY accepted with hready=1 produce a zero-wait OKAY data phase with no memory access.
- Error check at acceptance. Any one of the following gives error:
  - haddr >= DEPTH*4;
  - hsize > 010;
  - misalignment: halfword with haddr[0]=1, or word with haddr[1:0]!=0.
- State machine, states OKAY_IDLE, WAIT, ERR1, ERR2:
  - OKAY_IDLE: hready=1, hresp=00. On accepting an error transfer, go to ERR1. On accepting a good transfer with WAIT_STATES>0, go to WAIT and load wcnt=WAIT_STATES. Otherwise stay.
  - WAIT: hready=0, hresp=00. wcnt decrements each cycle. When wcnt=1, return to OKAY_IDLE; the data phase completes in that cycle.
  - ERR1: hready=0, hresp=01. Always go to ERR2 next.
  - ERR2: hready=1, hresp=01. The address phase presented here is accepted and decoded normally, with the same transitions as OKAY_IDLE.
- Write commit happens on the edge that ends the data phase (the edge where hready=1). Byte lanes are little-endian:
  - byte: lane haddr[1:0];
  - halfword: lanes {haddr[1],0}+{0,1};
  - word: all four lanes.
  - Unselected lanes are unchanged. Errored transfers never write.
- Read: during an OKAY read data phase, hrdata = mem[addr_q[..2]] as a full word, combinational from registered state. In all other cycles hrdata = 0.
- Back-to-back write A then read A returns the new data, because the write commits before the read data phase starts.

## Timing
- Reset values: state=OKAY_IDLE, hready=1, hresp=00, hrdata=0, wcnt=0.
- Reset does not clear memory contents.
- Reset mid-transfer aborts it. A write in its data phase at reset assertion is not committed.
- Latency: OKAY transfer data phase = WAIT_STATES+1 cycles. ERROR transfer = exactly 2 cycles.
- The next address phase overlaps the final data-phase cycle (full pipelining).
- hready, hresp and state are registered.
- hrdata comes only from registers and the memory array; there is no combinational path from any input.

## Structure
- Package global: AWIDTH, DWIDTH, and new HTRANS_*, HSIZE_*, HRESP_* constants.
- Package global also holds the slave_state_e typedef.
- One sub-module: ahb_slave_ram, a DEPTH x 32 array with a 4-bit byte-write-enable port and an asynchronous read port.

## Test plan
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 in the next cycle -> hready stays 1 and hrdata=0xDEADBEEF in the read data phase.
- Byte write 0xAA to 0x13 over prior word 0x11223344 @0x10 -> read returns 0xAA223344; halfword write 0x5566 to 0x10 -> 0xAA225566.
- WAIT_STATES=3: word read -> hready low for exactly 3 cycles, then high with valid hrdata; a following address phase is not sampled until hready=1.
- Read @DEPTH*4 (out of range), and word read @0x02 (misaligned) -> each gives hready=0/hresp=01, then hready=1/hresp=01, with memory unchanged.
- Next address phase presented during ERR2 is accepted, and a good read @0x10 returns 0xAA225566 with OKAY.
- rst_i asserted during a WAIT-state write data phase -> hready=1, hresp=00, hrdata=0 immediately; a subsequent read shows the old word, not the aborted write.

Source files
------------

// File: rtl/ahb_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem_pkg
//  Description : Shared widths, AHB encodings, slave FSM state type and the
//                byte-lane decode helper for the AHB slave memory.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_slave_mem_pkg;

   localparam int AWIDTH = 32;
   localparam int DWIDTH = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      OKAY_IDLE = 2'd0,
      WAIT      = 2'd1,
      ERR1      = 2'd2,
      ERR2      = 2'd3
   } slave_state_e;

   // Little-endian byte-lane mask for a transfer of the given size/offset.
   function automatic logic [3:0] byte_lanes(input logic [1:0] offs, input logic [2:0] size);
      logic [3:0] lanes;
      case (size)
         HSIZE_BYTE: lanes = 4'b0001 << offs;
         HSIZE_HALF: lanes = offs[1] ? 4'b1100 : 4'b0011;
         default:    lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem_if
//  Description : AHB address/data/response signal bundle between the bridge
//                (master) and the slave memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_slave_mem_if
   import ahb_slave_mem_pkg::*;
();
   logic [AWIDTH-1:0] haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [DWIDTH-1:0] hwdata;
   logic              hready;
   logic [1:0]        hresp;
   logic [DWIDTH-1:0] hrdata;

   modport master (
      output haddr, hwrite, htrans, hsize, hburst, hwdata,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  haddr, hwrite, htrans, hsize, hburst, hwdata,
      output hready, hresp, hrdata
   );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_ram
//  Description : DEPTH x 32 storage with per-byte write enables and an
//                asynchronous read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_slave_ram
   import ahb_slave_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  wire logic              clk_i,
   input  wire logic [3:0]        i_we,
   input  wire logic [IDX_W-1:0]  i_addr,
   input  wire logic [DWIDTH-1:0] i_wdata,
   output logic      [DWIDTH-1:0] o_rdata
);
   logic [DWIDTH-1:0] r_mem [DEPTH];

   // Byte-lane writes; unselected lanes keep their contents.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
   end

   assign o_rdata = r_mem[i_addr];
endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem
//  Description : Always-selected AHB slave memory with programmable wait
//                states, byte/halfword/word writes and a two-cycle ERROR.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_slave_mem
   import ahb_slave_mem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input wire logic        clk_i,
   input wire logic        rst_i,
   ahb_slave_mem_if.slave  bus
);
   localparam int              c_idx_w = $clog2(DEPTH);
   localparam logic [AWIDTH:0] c_limit = (AWIDTH+1)'(DEPTH * 4);
   localparam logic [3:0]      c_wait  = 4'(WAIT_STATES);

   slave_state_e      r_state, w_next_state;
   logic [3:0]        r_wcnt, w_next_wcnt;
   logic              r_hready, w_next_hready;
   logic [1:0]        r_hresp, w_next_hresp;
   logic              r_dphase, w_next_dphase;
   logic [AWIDTH-1:0] r_addr;
   logic              r_write;
   logic [2:0]        r_size;

   logic              w_accept;
   logic              w_err;
   logic [3:0]        w_we;
   logic [DWIDTH-1:0] w_rdata;
   logic              w_unused;

   assign w_accept = r_hready && bus.htrans[1];

   assign w_err = ({1'b0, bus.haddr} >= c_limit)
                || (bus.hsize > HSIZE_WORD)
                || ((bus.hsize == HSIZE_HALF) && bus.haddr[0])
                || ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));

   // Registered state, response and control; reset aborts any open transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= OKAY_IDLE;
         r_wcnt   <= 4'd0;
         r_hready <= 1'b1;
         r_hresp  <= HRESP_OKAY;
         r_dphase <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_wcnt   <= w_next_wcnt;
         r_hready <= w_next_hready;
         r_hresp  <= w_next_hresp;
         r_dphase <= w_next_dphase;
      end
   end

   // Address-phase capture on every accepted NONSEQ/SEQ beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr  <= '0;
         r_write <= 1'b0;
         r_size  <= HSIZE_BYTE;
      end else if (w_accept) begin
         r_addr  <= bus.haddr;
         r_write <= bus.hwrite;
         r_size  <= bus.hsize;
      end
   end

   // Next-state decode; ERR2 accepts a new address phase just like OKAY_IDLE.
   always_comb begin
      w_next_state  = r_state;
      w_next_wcnt   = r_wcnt;
      w_next_hready = r_hready;
      w_next_hresp  = r_hresp;
      w_next_dphase = r_dphase;
      case (r_state)
         WAIT: begin
            if (r_wcnt == 4'd1) begin
               w_next_state  = OKAY_IDLE;
               w_next_wcnt   = 4'd0;
               w_next_hready = 1'b1;
            end else begin
               w_next_wcnt = r_wcnt - 4'd1;
            end
         end
         ERR1: begin
            w_next_state  = ERR2;
            w_next_hready = 1'b1;
            w_next_hresp  = HRESP_ERROR;
         end
         default: begin
            w_next_state  = OKAY_IDLE;
            w_next_hready = 1'b1;
            w_next_hresp  = HRESP_OKAY;
            w_next_dphase = 1'b0;
            if (w_accept) begin
               if (w_err) begin
                  w_next_state  = ERR1;
                  w_next_hready = 1'b0;
                  w_next_hresp  = HRESP_ERROR;
               end else begin
                  w_next_dphase = 1'b1;
                  if (c_wait != 4'd0) begin
                     w_next_state  = WAIT;
                     w_next_hready = 1'b0;
                     w_next_wcnt   = c_wait;
                  end
               end
            end
         end
      endcase
   end

   // Write commits only on the edge closing a good write data phase.
   assign w_we = (r_hready && r_dphase && r_write && !rst_i)
               ? byte_lanes(r_addr[1:0], r_size) : 4'b0000;

   ahb_slave_ram #(
      .DEPTH (DEPTH),
      .IDX_W (c_idx_w)
   ) u_ram (
      .clk_i   (clk_i),
      .i_we    (w_we),
      .i_addr  (r_addr[c_idx_w+1:2]),
      .i_wdata (bus.hwdata),
      .o_rdata (w_rdata)
   );

   assign bus.hready = r_hready;
   assign bus.hresp  = r_hresp;
   assign bus.hrdata = (r_dphase && !r_write) ? w_rdata : '0;

   assign w_unused = &{1'b0, bus.hburst, bus.htrans[0], r_addr};
endmodule
`default_nettype wire
